// File: rtl/sg_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module : sg_mon_pkg
// Brief  : Shared types and transition-entry field helpers for sg_monitor.
// Rev    : 1.0
// ============================================================================
package sg_mon_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_INPUT  = 2'd1,
        ERR_OUTPUT = 2'd2,
        ERR_MULTI  = 2'd3
    } err_code_t;

    localparam int FIELD_W     = 8;
    localparam int ENTRY_MAX_W = 3 * FIELD_W + 2;

    typedef struct packed {
        logic               valid;
        logic [FIELD_W-1:0] from;
        logic [FIELD_W-1:0] sig;
        logic               dir;
        logic [FIELD_W-1:0] to;
    } entry_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed entry layout, LSB first: to[sw], dir, sig[iw], from[sw], valid.
    function automatic int entry_w(input int sw, input int iw);
        return 2 * sw + iw + 2;
    endfunction

    function automatic entry_t unpack_entry(input logic [ENTRY_MAX_W-1:0] raw,
                                            input int sw, input int iw);
        entry_t                 e;
        logic [ENTRY_MAX_W-1:0] m_s;
        logic [ENTRY_MAX_W-1:0] m_i;
        logic [ENTRY_MAX_W-1:0] sh_dir;
        logic [ENTRY_MAX_W-1:0] sh_val;
        m_s     = (ENTRY_MAX_W'(1) << sw) - ENTRY_MAX_W'(1);
        m_i     = (ENTRY_MAX_W'(1) << iw) - ENTRY_MAX_W'(1);
        sh_dir  = raw >> sw;
        sh_val  = raw >> (2 * sw + iw + 1);
        e.to    = FIELD_W'(raw & m_s);
        e.dir   = sh_dir[0];
        e.sig   = FIELD_W'((raw >> (sw + 1)) & m_i);
        e.from  = FIELD_W'((raw >> (sw + iw + 1)) & m_s);
        e.valid = sh_val[0];
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sg_mon_lookup.sv
`default_nettype none
// ============================================================================
// Module : sg_mon_lookup
// Brief  : Combinational table search (state, signal, direction) -> hit/to/idx.
// Rev    : 1.0
// ============================================================================
module sg_mon_lookup
    import sg_mon_pkg::*;
#(
    parameter int NSIG   = 4,
    parameter int NSTATE = 16,
    parameter int NTRANS = 32,
    parameter logic [NTRANS*entry_w(idx_w(NSTATE), idx_w(NSIG))-1:0] TR_TABLE = '0
) (
    input  logic [idx_w(NSTATE)-1:0] i_state,
    input  logic [idx_w(NSIG)-1:0]   i_sig,
    input  logic                     i_dir,
    output logic                     o_hit,
    output logic [idx_w(NSTATE)-1:0] o_to,
    output logic [idx_w(NTRANS)-1:0] o_idx
);
    localparam int SW = idx_w(NSTATE);
    localparam int IW = idx_w(NSIG);
    localparam int TW = idx_w(NTRANS);
    localparam int EW = entry_w(SW, IW);

    entry_t w_e;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_to  = '0;
        o_idx = '0;
        w_e   = '0;
        for (int t = NTRANS - 1; t >= 0; t--) begin
            w_e = unpack_entry(ENTRY_MAX_W'(TR_TABLE[t*EW +: EW]), SW, IW);
            if (w_e.valid && (w_e.from == FIELD_W'(i_state)) &&
                (w_e.sig == FIELD_W'(i_sig)) && (w_e.dir == i_dir)) begin
                o_hit = 1'b1;
                o_to  = SW'(w_e.to);
                o_idx = TW'(t);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sg_monitor.sv
`default_nettype none
// ============================================================================
// Module : sg_monitor
// Brief  : Table-driven state-graph conformance monitor with sticky error
//          capture and saturating fire counter. Optional stall watchdog is
//          built when SG_MONITOR_WATCHDOG_EN is defined.
// Rev    : 1.0
// ============================================================================
module sg_monitor
    import sg_mon_pkg::*;
#(
    parameter int              NSIG     = 4,
    parameter int              NSTATE   = 16,
    parameter int              NTRANS   = 32,
    parameter logic [NSIG-1:0] OUT_MASK = '0,
    parameter int              INIT_ST  = 0,
    parameter logic [NSIG-1:0] INIT_VAL = '0,
    parameter logic [NTRANS*entry_w(idx_w(NSTATE), idx_w(NSIG))-1:0] TR_TABLE = '0,
    parameter int              CNT_W    = 16,
    parameter int              TIMEOUT  = 256
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSIG-1:0]          sig_in,
    input  logic                     clear,
    output logic [idx_w(NSTATE)-1:0] state_o,
    output logic                     fire_o,
    output logic [idx_w(NTRANS)-1:0] fire_idx,
    output logic                     err_o,
    output logic [1:0]               err_code,
    output logic [idx_w(NSIG)-1:0]   err_sig,
    output logic [CNT_W-1:0]         tr_cnt,
    output logic                     stall_o
);
    localparam int SW = idx_w(NSTATE);
    localparam int IW = idx_w(NSIG);
    localparam int TW = idx_w(NTRANS);

    logic [SW-1:0]   r_state;
    logic [NSIG-1:0] r_sig_prev;
    logic            r_fire;
    logic [TW-1:0]   r_fire_idx;
    logic            r_err;
    err_code_t       r_err_code;
    logic [IW-1:0]   r_err_sig;
    logic [CNT_W-1:0] r_cnt;

    logic [NSIG-1:0] w_edge;
    logic            w_single;
    logic            w_multi;
    logic [IW-1:0]   w_low;
    logic [NSIG-1:0] w_sig_sh;
    logic [NSIG-1:0] w_mask_sh;
    logic            w_hit;
    logic [SW-1:0]   w_to;
    logic [TW-1:0]   w_idx;
    logic            w_fire;
    logic            w_viol;
    err_code_t       w_code;

    assign w_edge    = sig_in ^ r_sig_prev;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_single  = (w_edge != '0) && ((w_edge & (w_edge - NSIG'(1))) == '0);
    assign w_multi   = (w_edge != '0) && !w_single;
    assign w_sig_sh  = sig_in >> w_low;
    assign w_mask_sh = OUT_MASK >> w_low;

    always_comb begin
        w_low = '0;
        for (int i = NSIG - 1; i >= 0; i--) begin
            if (w_edge[i]) w_low = IW'(i);
        end
    end

    sg_mon_lookup #(
        .NSIG     (NSIG),
        .NSTATE   (NSTATE),
        .NTRANS   (NTRANS),
        .TR_TABLE (TR_TABLE)
    ) u_lookup (
        .i_state (r_state),
        .i_sig   (w_low),
        .i_dir   (w_sig_sh[0]),
        .o_hit   (w_hit),
        .o_to    (w_to),
        .o_idx   (w_idx)
    );

    assign w_fire = w_single && w_hit;
    assign w_viol = w_multi || (w_single && !w_hit);
    assign w_code = w_multi ? ERR_MULTI : (w_mask_sh[0] ? ERR_OUTPUT : ERR_INPUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= SW'(INIT_ST);
            r_sig_prev <= INIT_VAL;
            r_fire     <= 1'b0;
            r_fire_idx <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_sig  <= '0;
            r_cnt      <= '0;
        end else begin
            r_sig_prev <= sig_in;
            r_fire     <= w_fire;
            if (w_fire) begin
                r_state    <= w_to;
                r_fire_idx <= w_idx;
            end
            // A violation alongside clear is recorded as the new first error.
            if (w_viol && (!r_err || clear)) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                r_err_sig  <= w_low;
            end else if (clear) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_err_sig  <= '0;
            end
            if (clear) begin
                r_cnt <= w_fire ? CNT_W'(1) : '0;
            end else if (w_fire && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SG_MONITOR_WATCHDOG_EN
    localparam int WDW = idx_w(TIMEOUT + 1);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_stall;
    logic           w_owes;
    entry_t         w_we;
    logic [NSIG-1:0] w_we_mask;

    // The circuit owes a move when the current state has a live exit on an output signal.
    always_comb begin
        w_owes    = 1'b0;
        w_we      = '0;
        w_we_mask = '0;
        for (int t = 0; t < NTRANS; t++) begin
            w_we      = unpack_entry(ENTRY_MAX_W'(TR_TABLE[t*entry_w(SW, IW) +: entry_w(SW, IW)]), SW, IW);
            w_we_mask = OUT_MASK >> w_we.sig;
            if (w_we.valid && (w_we.from == FIELD_W'(r_state)) && w_we_mask[0]) w_owes = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_fire || clear) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != WDW'(TIMEOUT)) begin
                r_wd_cnt <= r_wd_cnt + WDW'(1);
            end
            if (clear) begin
                r_stall <= 1'b0;
            end else if ((r_wd_cnt == WDW'(TIMEOUT)) && w_owes) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign stall_o = r_stall;
`else
    assign stall_o = 1'b0;
`endif

    assign state_o  = r_state;
    assign fire_o   = r_fire;
    assign fire_idx = r_fire_idx;
    assign err_o    = r_err;
    assign err_code = r_err_code;
    assign err_sig  = r_err_sig;
    assign tr_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sg_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_sg_monitor
// Brief  : Directed bench for sg_monitor on a req(in)/ack(out) 4-phase graph.
// Rev    : 1.0
// ============================================================================
module tb_sg_monitor;

    // Entries, LSB-first index 0..4: {valid, from[2], sig, dir, to[2]}; entry 4 is disabled.
    localparam logic [34:0] TBL = {7'b0_00_1_1_10, 7'b1_11_1_0_00, 7'b1_10_0_0_11,
                                   7'b1_01_1_1_10, 7'b1_00_0_1_01};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sig_in = 2'b00;
    logic       clear = 1'b0;
    logic [1:0] state_o;
    logic       fire_o;
    logic [2:0] fire_idx;
    logic       err_o;
    logic [1:0] err_code;
    logic       err_sig;
    logic [2:0] tr_cnt;
    logic       stall_o;

    int n_vec = 0;
    int n_mis = 0;

    sg_monitor #(
        .NSIG(2), .NSTATE(4), .NTRANS(5), .OUT_MASK(2'b10), .INIT_ST(0),
        .INIT_VAL(2'b00), .TR_TABLE(TBL), .CNT_W(3), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .clear(clear),
        .state_o(state_o), .fire_o(fire_o), .fire_idx(fire_idx), .err_o(err_o),
        .err_code(err_code), .err_sig(err_sig), .tr_cnt(tr_cnt), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sig_in = 2'b00;
        step(); step();
        n_vec++; if (state_o !== 2'd0) begin n_mis++; $display("FAIL reset_state got %0d want 0", state_o); end
        n_vec++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err got %0b want 0", err_o); end
        n_vec++; if (err_code !== 2'd0) begin n_mis++; $display("FAIL reset_code got %0d want 0", err_code); end
        n_vec++; if (tr_cnt !== 3'd0) begin n_mis++; $display("FAIL reset_cnt got %0d want 0", tr_cnt); end
        n_vec++; if (fire_o !== 1'b0) begin n_mis++; $display("FAIL reset_fire got %0b want 0", fire_o); end
        n_vec++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL reset_stall got %0b want 0", stall_o); end
        reset = 1'b0;
    endtask

    task automatic test_walk();
        logic [1:0] pat [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        logic [1:0] exp_st [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            sig_in = pat[i];
            step();
            n_vec++; if (state_o !== exp_st[i]) begin n_mis++; $display("FAIL walk_state[%0d] got %0d want %0d", i, state_o, exp_st[i]); end
            n_vec++; if (fire_o !== 1'b1) begin n_mis++; $display("FAIL walk_fire[%0d] got %0b want 1", i, fire_o); end
            n_vec++; if (fire_idx !== 3'(i)) begin n_mis++; $display("FAIL walk_idx[%0d] got %0d want %0d", i, fire_idx, i); end
        end
        n_vec++; if (tr_cnt !== 3'd4) begin n_mis++; $display("FAIL walk_cnt got %0d want 4", tr_cnt); end
        n_vec++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL walk_err got %0b want 0", err_o); end
        step();
        n_vec++; if (fire_o !== 1'b0) begin n_mis++; $display("FAIL walk_idle_fire got %0b want 0", fire_o); end
    endtask

    task automatic test_output_violation();
        sig_in = 2'b10;
        step();
        n_vec++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL outv_err got %0b want 1", err_o); end
        n_vec++; if (err_code !== 2'd2) begin n_mis++; $display("FAIL outv_code got %0d want 2", err_code); end
        n_vec++; if (err_sig !== 1'b1) begin n_mis++; $display("FAIL outv_sig got %0d want 1", err_sig); end
        n_vec++; if (state_o !== 2'd0) begin n_mis++; $display("FAIL outv_state got %0d want 0", state_o); end
        n_vec++; if (fire_o !== 1'b0) begin n_mis++; $display("FAIL outv_fire got %0b want 0", fire_o); end
        sig_in = 2'b00;
        do_reset();
    endtask

    task automatic test_input_violation();
        sig_in = 2'b01; step();
        sig_in = 2'b00; step();
        n_vec++; if (err_code !== 2'd1) begin n_mis++; $display("FAIL inv_code got %0d want 1", err_code); end
        n_vec++; if (err_sig !== 1'b0) begin n_mis++; $display("FAIL inv_sig got %0d want 0", err_sig); end
        n_vec++; if (state_o !== 2'd1) begin n_mis++; $display("FAIL inv_state got %0d want 1", state_o); end
        sig_in = 2'b10; step();
        n_vec++; if (state_o !== 2'd2) begin n_mis++; $display("FAIL inv_adv_state got %0d want 2", state_o); end
        sig_in = 2'b00; step();
        n_vec++; if (err_code !== 2'd1) begin n_mis++; $display("FAIL inv_keep_code got %0d want 1", err_code); end
        n_vec++; if (err_sig !== 1'b0) begin n_mis++; $display("FAIL inv_keep_sig got %0d want 0", err_sig); end
        do_reset();
    endtask

    task automatic test_multi_edge();
        sig_in = 2'b11; step();
        n_vec++; if (err_code !== 2'd3) begin n_mis++; $display("FAIL multi_code got %0d want 3", err_code); end
        n_vec++; if (err_sig !== 1'b0) begin n_mis++; $display("FAIL multi_sig got %0d want 0", err_sig); end
        n_vec++; if (state_o !== 2'd0) begin n_mis++; $display("FAIL multi_state got %0d want 0", state_o); end
        n_vec++; if (fire_o !== 1'b0) begin n_mis++; $display("FAIL multi_fire got %0b want 0", fire_o); end
        sig_in = 2'b00;
        do_reset();
    endtask

    task automatic test_clear();
        sig_in = 2'b01; step();
        sig_in = 2'b11; step();
        sig_in = 2'b01; step();
        n_vec++; if (err_code !== 2'd2) begin n_mis++; $display("FAIL clr_pre_code got %0d want 2", err_code); end
        clear = 1'b1; step();
        n_vec++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL clr_err got %0b want 0", err_o); end
        n_vec++; if (tr_cnt !== 3'd0) begin n_mis++; $display("FAIL clr_cnt got %0d want 0", tr_cnt); end
        n_vec++; if (state_o !== 2'd2) begin n_mis++; $display("FAIL clr_state got %0d want 2", state_o); end
        sig_in = 2'b00; step();
        n_vec++; if (tr_cnt !== 3'd1) begin n_mis++; $display("FAIL clr_fire_cnt got %0d want 1", tr_cnt); end
        n_vec++; if (state_o !== 2'd3) begin n_mis++; $display("FAIL clr_fire_state got %0d want 3", state_o); end
        sig_in = 2'b01; step();
        n_vec++; if (err_o !== 1'b1) begin n_mis++; $display("FAIL clr_viol_err got %0b want 1", err_o); end
        n_vec++; if (err_code !== 2'd1) begin n_mis++; $display("FAIL clr_viol_code got %0d want 1", err_code); end
        clear = 1'b0;
        do_reset();
        n_vec++; if (state_o !== 2'd0) begin n_mis++; $display("FAIL midrst_state got %0d want 0", state_o); end
        n_vec++; if (err_o !== 1'b0) begin n_mis++; $display("FAIL midrst_err got %0b want 0", err_o); end
        step();
        n_vec++; if (state_o !== 2'd1) begin n_mis++; $display("FAIL postrst_state got %0d want 1", state_o); end
        sig_in = 2'b00;
        do_reset();
    endtask

    task automatic test_saturate();
        logic [1:0] pat [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int k = 0; k < 8; k++) begin
            sig_in = pat[k % 4];
            step();
        end
        n_vec++; if (tr_cnt !== 3'd7) begin n_mis++; $display("FAIL sat_cnt got %0d want 7", tr_cnt); end
        n_vec++; if (state_o !== 2'd0) begin n_mis++; $display("FAIL sat_state got %0d want 0", state_o); end
    endtask

    task automatic test_watchdog();
        logic exp_stall;
`ifdef SG_MONITOR_WATCHDOG_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        sig_in = 2'b01; step();
        for (int k = 0; k < 4; k++) step();
        n_vec++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL wd_early got %0b want 0", stall_o); end
        for (int k = 0; k < 8; k++) step();
        n_vec++; if (stall_o !== exp_stall) begin n_mis++; $display("FAIL wd_s1 got %0b want %0b", stall_o, exp_stall); end
        clear = 1'b1; step(); clear = 1'b0;
        n_vec++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL wd_clr got %0b want 0", stall_o); end
        sig_in = 2'b00;
        do_reset();
        for (int k = 0; k < 12; k++) step();
        n_vec++; if (stall_o !== 1'b0) begin n_mis++; $display("FAIL wd_s0 got %0b want 0", stall_o); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_output_violation();
        test_input_violation();
        test_multi_edge();
        test_clear();
        test_saturate();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
